// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one synchronous FIFO write port among NUM_REQ producers.
// Bursts of up to MAX_BURST words per owner; sticky flags track missing write acks and overflow.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          full,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy,
    output logic                          ack_err,
    output logic                          ovf_err
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t          state;
    logic [OW-1:0]   rr_ptr;
    logic [BW-1:0]   burst_cnt;
    logic            wr_en_q;
    logic [OW-1:0]   winner;
    logic [OW-1:0]   cand;
    logic            found;

    // Explicit wrap keeps the index legal when NUM_REQ is not a power of two.
    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        winner = rr_ptr;
        cand   = rr_ptr;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
            cand = next_idx(cand);
        end
    end

    always_comb begin
        gnt = '0;
        if (state == OWN && req[owner] && !full) begin
            gnt[owner] = 1'b1;
        end
        wr_en   = |gnt;
        data_in = wr_en ? req_data[owner*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            busy      <= 1'b0;
            wr_en_q   <= 1'b0;
            ack_err   <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            wr_en_q <= wr_en;
            if (wr_en_q && !wr_ack) begin
                ack_err <= 1'b1;
            end
            if (overflow) begin
                ovf_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= winner;
                        burst_cnt <= '0;
                        state     <= OWN;
                        busy      <= 1'b1;
                    end
                end
                OWN: begin
                    // A full stall leaves the count and ownership untouched.
                    if (!req[owner]) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_idx(owner);
                    end else if (wr_en) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (burst_cnt == LAST_BEAT) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= next_idx(owner);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Cycle-by-cycle vector bench for fifo_wr_arbiter; written words are checked through a scoreboard queue.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int FW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*FW-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic             wr_en;
    logic [FW-1:0]    data_in;
    logic             full;
    logic             wr_ack;
    logic             overflow;
    logic [1:0]       owner;
    logic             busy;
    logic             ack_err;
    logic             ovf_err;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(FW), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .wr_en(wr_en), .data_in(data_in), .full(full), .wr_ack(wr_ack),
        .overflow(overflow), .owner(owner), .busy(busy), .ack_err(ack_err),
        .ovf_err(ovf_err)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic        full;
        logic        drop_ack;
        logic        ovf;
        logic [3:0]  e_gnt;
        logic [1:0]  e_owner;
        logic        e_busy;
        logic        e_ack_err;
        logic        e_ovf_err;
        logic [15:0] e_data;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          wcnt[NR];
    logic        last_wr_en = 1'b0;

    task automatic addVec(input logic r, input logic [3:0] rq, input logic f, input logic d,
                          input logic o, input logic [3:0] g, input logic [1:0] ow,
                          input logic b, input logic ae, input logic oe, input logic [15:0] dat);
        vec_t v;
        v.rst_n = r; v.req = rq; v.full = f; v.drop_ack = d; v.ovf = o;
        v.e_gnt = g; v.e_owner = ow; v.e_busy = b; v.e_ack_err = ae; v.e_ovf_err = oe;
        v.e_data = dat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Producers present word p*0x100 + n + 1 and advance only after being granted.
    task automatic applyStimulus(input vec_t v);
        rst_n    = v.rst_n;
        req      = v.req;
        full     = v.full;
        overflow = v.ovf;
        wr_ack   = last_wr_en && !v.drop_ack;
        for (int p = 0; p < NR; p++) begin
            req_data[p*FW +: FW] = 16'(p * 256 + wcnt[p] + 1);
        end
        if (|v.e_gnt) begin
            sb_q.push_back(v.e_data);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic [15:0] exp_word;
        @(negedge clk);
        check($sformatf("gnt v%0d", idx), 32'(gnt), 32'(v.e_gnt));
        check($sformatf("wr_en v%0d", idx), 32'(wr_en), 32'(|v.e_gnt));
        check($sformatf("owner v%0d", idx), 32'(owner), 32'(v.e_owner));
        check($sformatf("busy v%0d", idx), 32'(busy), 32'(v.e_busy));
        check($sformatf("ack_err v%0d", idx), 32'(ack_err), 32'(v.e_ack_err));
        check($sformatf("ovf_err v%0d", idx), 32'(ovf_err), 32'(v.e_ovf_err));
        if (wr_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_unexpected_write v%0d: got %0h expected no write", idx, data_in);
            end else begin
                exp_word = sb_q.pop_front();
                check($sformatf("data_in v%0d", idx), 32'(data_in), 32'(exp_word));
            end
        end else begin
            check($sformatf("data_in_idle v%0d", idx), 32'(data_in), 32'h0);
        end
        for (int p = 0; p < NR; p++) begin
            if (gnt[p]) wcnt[p]++;
        end
        last_wr_en = wr_en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_data = '0; full = 1'b0; wr_ack = 1'b0; overflow = 1'b0;
        for (int p = 0; p < NR; p++) wcnt[p] = 0;

        // Reset values, then a single producer: 4-word burst, one idle, 2 words, release
        addVec(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);
        addVec(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);
        for (int k = 0; k < 4; k++) addVec(1, 4'b0001, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 16'(1 + k));
        addVec(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);
        addVec(1, 4'b0001, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 16'h0005);
        addVec(1, 4'b0001, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 16'h0006);
        addVec(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 0, 0, 16'h0);
        addVec(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);

        // Reset, then all four request: owners rotate 0..3 and wrap back to 0
        addVec(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);
        addVec(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                addVec(1, 4'b1111, 0, 0, 0, 4'(1 << b), 2'(b), 1, 0, 0,
                       (b == 0) ? 16'(7 + k) : 16'(b * 256 + 1 + k));
            end
            addVec(1, 4'b1111, 0, 0, 0, 4'b0000, 2'(b), 0, 0, 0, 16'h0);
        end

        // Owner 0 again; full stalls for 3 cycles after its 2nd word
        addVec(1, 4'b1111, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 16'h000B);
        addVec(1, 4'b1111, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 16'h000C);
        for (int k = 0; k < 3; k++) addVec(1, 4'b1111, 1, 0, 0, 4'b0000, 0, 1, 0, 0, 16'h0);
        addVec(1, 4'b1111, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 16'h000D);
        addVec(1, 4'b1111, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 16'h000E);

        // Early release by producer 1 hands over to producer 2 after one idle cycle
        addVec(1, 4'b0110, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);
        addVec(1, 4'b0110, 0, 0, 0, 4'b0010, 1, 1, 0, 0, 16'h0105);
        addVec(1, 4'b0110, 0, 0, 0, 4'b0010, 1, 1, 0, 0, 16'h0106);
        addVec(1, 4'b0100, 0, 0, 0, 4'b0000, 1, 1, 0, 0, 16'h0);
        addVec(1, 4'b0100, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 16'h0);
        addVec(1, 4'b0100, 0, 0, 0, 4'b0100, 2, 1, 0, 0, 16'h0205);

        // Reset during owner 2's second word; search restarts at index 0 so producer 1 wins
        addVec(0, 4'b0100, 0, 0, 0, 4'b0100, 2, 1, 0, 0, 16'h0206);
        addVec(1, 4'b0110, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);
        addVec(1, 4'b0110, 0, 0, 0, 4'b0010, 1, 1, 0, 0, 16'h0107);

        // Missing ack and an overflow pulse set sticky flags until the next reset
        addVec(1, 4'b0110, 0, 1, 0, 4'b0010, 1, 1, 0, 0, 16'h0108);
        addVec(1, 4'b0110, 0, 0, 1, 4'b0010, 1, 1, 1, 0, 16'h0109);
        addVec(1, 4'b0110, 0, 0, 0, 4'b0010, 1, 1, 1, 1, 16'h010A);
        addVec(1, 4'b0100, 0, 0, 0, 4'b0000, 1, 0, 1, 1, 16'h0);
        addVec(1, 4'b0100, 0, 0, 0, 4'b0100, 2, 1, 1, 1, 16'h0207);
        addVec(1, 4'b0000, 0, 0, 0, 4'b0000, 2, 1, 1, 1, 16'h0);
        addVec(1, 4'b0000, 0, 0, 0, 4'b0000, 2, 0, 1, 1, 16'h0);
        addVec(0, 4'b0000, 0, 0, 0, 4'b0000, 2, 0, 1, 1, 16'h0);
        addVec(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);

        // Owner drops req in the same cycle full rises: no write, back to idle
        addVec(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);
        addVec(1, 4'b0001, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 16'h000F);
        addVec(1, 4'b0000, 1, 0, 0, 4'b0000, 0, 1, 0, 0, 16'h0);
        addVec(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end
        check("sb_leftover", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the synchronous FIFO among `NUM_REQ` producers. Each producer uses a req/gnt (valid/ready) handshake. The arbiter keeps one owner for a burst of up to `MAX_BURST` words, and never issues `wr_en` while the FIFO reports `full`. It also monitors `wr_ack` and `overflow` and raises sticky error flags for the SPI/RAM subsystem status register.

## Interface
- `NUM_REQ`, 4: number of producers (2..8).
- `FIFO_WIDTH`, 16: data word width; matches the FIFO data width.
- `MAX_BURST`, 4: maximum words per ownership period (≥1).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `req`  in  NUM_REQ  per-producer request; word valid while high.
- `req_data`  in  NUM_REQ*FIFO_WIDTH  producer words; producer i at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- `gnt`  out  NUM_REQ  per-producer accept, combinational, one-hot or zero.
- `wr_en`  out  1  FIFO write enable.
- `data_in`  out  FIFO_WIDTH  FIFO write data.
- `full`  in  1  FIFO full flag (current occupancy).
- `wr_ack`  in  1  FIFO write acknowledge, registered by the FIFO.
- `overflow`  in  1  FIFO overflow flag.
- `owner`  out  $clog2(NUM_REQ)  current owner index (registered).
- `busy`  out  1  high in state OWN.
- `ack_err`  out  1  sticky: an expected `wr_ack` was missing.
- `ovf_err`  out  1  sticky: FIFO `overflow` was observed.

## Operation
- FSM has two states.
  - IDLE: no owner.
  - OWN: `owner` holds the write port.
- In IDLE, if `|req`:
  - The winner is the first requester with `req` high, searching from `rr_ptr` upward with wrap-around.
  - Update `owner <= winner`, `burst_cnt <= 0`, go to OWN.
  - No transfer occurs in IDLE.
- In OWN:
  - `gnt[owner] = req[owner] && !full`; every other `gnt` bit is 0.
  - `wr_en = |gnt`.
  - `data_in = wr_en ? req_data[owner] : 0`.
  - A transfer is any cycle with `wr_en` high. Each transfer increments `burst_cnt`.
- OWN → IDLE, with `rr_ptr <= (owner+1) mod NUM_REQ`, when either:
  - `req[owner]` is low, or
  - a transfer occurs with `burst_cnt == MAX_BURST-1`.
- `full` high with `req[owner]` high is a stall:
  - stay in OWN;
  - `burst_cnt` holds;
  - `gnt` stays 0.
- Producers must hold `req` and `req_data` stable until they see `gnt`. After `gnt`, they advance to the next word or drop `req`.
- Monitors:
  - `ack_err` is set if `wr_en` was high in the previous cycle and `wr_ack` is low now.
  - `ovf_err` is set whenever `overflow` is high.
  - Both flags clear only on reset.

## Timing
- Reset applies at any rising edge with `rst_n` low, including mid-burst. Reset values:
  - state = IDLE, `owner` = 0, `rr_ptr` = 0, `burst_cnt` = 0;
  - `busy`, `ack_err`, `ovf_err` = 0;
  - `gnt` = 0, `wr_en` = 0, `data_in` = 0, since they are derived from IDLE.
- The first accepted word after reset is at the edge after `rst_n` rises, at the earliest.
- Latency: `req` sampled high in IDLE at edge t gives the first `gnt` in cycle t+1, if `full` is low.
- Sustained throughput is one word per cycle within a burst.
- Re-arbitration costs exactly one IDLE cycle between bursts.
- Overflow is impossible by construction, because `wr_en` is gated by the current `full`.
- `full` falling re-enables `gnt` in the same cycle.
- Simultaneous events:
  - `req[owner]` drop and `full` in the same cycle: no transfer, go to IDLE.
  - A last-burst transfer while other producers request: `rr_ptr` advances past the owner, so the next-index requester wins.
  - Requesters that rise while in OWN wait for the next IDLE.
- Widths:
  - `burst_cnt` is $clog2(MAX_BURST+1) bits.
  - `rr_ptr` and `owner` increment modulo `NUM_REQ`, with explicit wrap for non-power-of-2 values.

## Test plan
- Single producer, basic burst:
  - Stimulus: reset, then `req[0]` held with words 0x0001..0x0006, `full`=0.
  - Required: `gnt[0]` in cycles 1-4 writing 0x0001..0x0004, one IDLE cycle, then 0x0005..0x0006.
  - Required: `ack_err`=0 given a well-behaved `wr_ack`.
- Round-robin fairness:
  - Stimulus: `req[3:0]` all held.
  - Required: owners rotate 0,1,2,3,0, each writing 4 words with one idle cycle between bursts. `owner` wraps from 3 to 0.
- Full stall:
  - Stimulus: `full` forced high after the 2nd word of a burst for 3 cycles.
  - Required: `gnt`=0 and `wr_en`=0 for those 3 cycles; `busy` stays 1; words 3-4 are written after `full` falls.
- Early release:
  - Stimulus: `req[1]` drops after 2 words while `req[2]` is high.
  - Required: IDLE for 1 cycle, then owner=2; `rr_ptr`=2.
- Reset mid-burst:
  - Stimulus: `rst_n` low for 1 edge during owner 2's second word.
  - Required: next cycle `gnt`=0, `wr_en`=0, `data_in`=0, `busy`=0; after reset the next grant goes to the lowest-index active requester, starting from 0.
- Error flags:
  - Stimulus: suppress `wr_ack` once after a write; pulse `overflow` once.
  - Required: `ack_err` and `ovf_err` go to 1 at the following edge and stay 1 until reset.
